// File: rtl/tc_pkg.sv
// Shared encodings for the round-robin traffic-light controller.
package tc_pkg;

    localparam int unsigned LIGHT_W = 3;

    localparam logic [LIGHT_W-1:0] LT_GREEN  = 3'b001;
    localparam logic [LIGHT_W-1:0] LT_YELLOW = 3'b010;
    localparam logic [LIGHT_W-1:0] LT_RED    = 3'b100;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        ALLRED = 2'd2
    } phase_e;

endpackage

// File: rtl/tc_rr_pick.sv
// Combinational round-robin search: first requester after cur_i, wrapping, excluding cur_i.
module tc_rr_pick #(
    parameter int unsigned N_WAY = 2
) (
    input  logic [N_WAY-1:0]         req_i,
    input  logic [$clog2(N_WAY)-1:0] cur_i,
    output logic [$clog2(N_WAY)-1:0] next_o,
    output logic                     valid_o
);

    localparam int unsigned IDX_W = $clog2(N_WAY);

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        next_o  = cur_i;
        valid_o = 1'b0;
        for (int unsigned k = N_WAY - 1; k > 0; k--) begin
            if (req_i[IDX_W'((32'(cur_i) + k) % N_WAY)]) begin
                next_o  = IDX_W'((32'(cur_i) + k) % N_WAY);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tc_rr_ctrl.sv
// N-way traffic-light controller: round-robin service with min/max green,
// fixed yellow and optional all-red clearance; all lights registered.
module tc_rr_ctrl
    import tc_pkg::*;
#(
    parameter int unsigned N_WAY      = 2,
    parameter int unsigned MIN_GREEN  = 4,
    parameter int unsigned MAX_GREEN  = 16,
    parameter int unsigned YELLOW_CYC = 2,
    parameter int unsigned ALLRED_CYC = 1
) (
    input  logic                     CLK,
    input  logic                     R,
    input  logic [N_WAY-1:0]         T,
    output logic [3*N_WAY-1:0]       L,
    output logic [$clog2(N_WAY)-1:0] G_IDX,
    output logic [1:0]               PH
);

    localparam int unsigned IDX_W   = $clog2(N_WAY);
    localparam int unsigned TMR_A   = (MAX_GREEN > YELLOW_CYC) ? MAX_GREEN : YELLOW_CYC;
    localparam int unsigned TMR_MAX = (TMR_A > ALLRED_CYC) ? TMR_A : ALLRED_CYC;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [3*N_WAY-1:0] L_RST = {{(N_WAY-1){LT_RED}}, LT_GREEN};

    if (N_WAY < 2 || N_WAY > 8) begin : g_bad_nway
        $error("tc_rr_ctrl: N_WAY must be in 2..8");
    end
    if (MAX_GREEN < MIN_GREEN || MIN_GREEN < 1 || YELLOW_CYC < 1) begin : g_bad_timing
        $error("tc_rr_ctrl: need 1 <= MIN_GREEN <= MAX_GREEN and YELLOW_CYC >= 1");
    end

    phase_e               state_q, state_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic [TMR_W:0]       tmr_inc;
    logic [IDX_W-1:0]     gidx_q, gidx_d;
    logic [IDX_W-1:0]     next_q, next_d;
    logic [3*N_WAY-1:0]   l_q, l_d;
    logic [IDX_W-1:0]     pick_idx;
    logic                 other_dem;
    logic [N_WAY-1:0]     non_red;

    tc_rr_pick #(.N_WAY(N_WAY)) u_pick (
        .req_i   (T),
        .cur_i   (gidx_q),
        .next_o  (pick_idx),
        .valid_o (other_dem)
    );

    assign tmr_inc = {1'b0, tmr_q} + (TMR_W+1)'(1);

    // State and datapath registers.
    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            state_q <= GREEN;
            tmr_q   <= '0;
            gidx_q  <= '0;
            next_q  <= '0;
            l_q     <= L_RST;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            gidx_q  <= gidx_d;
            next_q  <= next_d;
            l_q     <= l_d;
        end
    end

    // Next-state: exit decision uses the count including the current cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            GREEN: begin
                if (other_dem && tmr_inc >= (TMR_W+1)'(MIN_GREEN)
                    && (!T[gidx_q] || tmr_inc >= (TMR_W+1)'(MAX_GREEN))) begin
                    state_d = YELLOW;
                end
            end
            YELLOW: begin
                if (tmr_inc >= (TMR_W+1)'(YELLOW_CYC)) begin
                    state_d = (ALLRED_CYC == 0) ? GREEN : ALLRED;
                end
            end
            ALLRED: begin
                if (tmr_inc >= (TMR_W+1)'(ALLRED_CYC)) begin
                    state_d = GREEN;
                end
            end
            default: state_d = GREEN;
        endcase
    end

    // Timer, handover target and current owner.
    always_comb begin
        tmr_d  = tmr_q;
        gidx_d = gidx_q;
        next_d = next_q;
        if (state_d != state_q) begin
            tmr_d = '0;
        end else if (state_q != GREEN || tmr_q != TMR_W'(MAX_GREEN)) begin
            tmr_d = tmr_q + TMR_W'(1);
        end
        if (state_q == GREEN && state_d == YELLOW) begin
            next_d = pick_idx;
        end
        if (state_q != GREEN && state_d == GREEN) begin
            gidx_d = next_q;
        end
    end

    // Light pattern for the upcoming cycle, registered so lights never glitch.
    always_comb begin
        l_d = '0;
        for (int unsigned i = 0; i < N_WAY; i++) begin
            if (gidx_d == IDX_W'(i) && state_d == GREEN) begin
                l_d[3*i +: 3] = LT_GREEN;
            end else if (gidx_d == IDX_W'(i) && state_d == YELLOW) begin
                l_d[3*i +: 3] = LT_YELLOW;
            end else begin
                l_d[3*i +: 3] = LT_RED;
            end
        end
    end

    assign L     = l_q;
    assign G_IDX = gidx_q;
    assign PH    = state_q;

    always_comb begin
        non_red = '0;
        for (int unsigned i = 0; i < N_WAY; i++) begin
            non_red[i] = (l_q[3*i +: 3] != LT_RED);
        end
    end

    a_single_non_red: assert property (@(posedge CLK) disable iff (R) $onehot0(non_red));

endmodule

// File: tb/tb_tc_rr_ctrl.sv
// Random and directed stimulus for tc_rr_ctrl (2-way and 4-way) against a cycle-level reference model.
module tb_tc_rr_ctrl;

    typedef struct {
        int n;
        int mn;
        int mx;
        int yc;
        int ac;
        int owner;
        int ph;
        int age;
        int left;
        int nxt;
    } mdl_t;

    logic        CLK;
    logic        R;
    logic [1:0]  T2;
    logic [5:0]  L2;
    logic [0:0]  G2;
    logic [1:0]  PH2;
    logic [3:0]  T4;
    logic [11:0] L4;
    logic [1:0]  G4;
    logic [1:0]  PH4;

    int   n_chk;
    int   n_err;
    mdl_t m2;
    mdl_t m4;

    tc_rr_ctrl #(.N_WAY(2), .MIN_GREEN(4), .MAX_GREEN(8), .YELLOW_CYC(2), .ALLRED_CYC(1)) dut2 (
        .CLK(CLK), .R(R), .T(T2), .L(L2), .G_IDX(G2), .PH(PH2)
    );

    tc_rr_ctrl #(.N_WAY(4), .MIN_GREEN(4), .MAX_GREEN(8), .YELLOW_CYC(2), .ALLRED_CYC(1)) dut4 (
        .CLK(CLK), .R(R), .T(T4), .L(L4), .G_IDX(G4), .PH(PH4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic mdl_t mreset(input mdl_t m);
        mdl_t r;
        r       = m;
        r.owner = 0;
        r.ph    = 0;
        r.age   = 0;
        r.left  = 0;
        r.nxt   = 0;
        return r;
    endfunction

    // One clock edge of the light sequence, driven by the sensor value seen at that edge.
    function automatic mdl_t step(input mdl_t m, input logic [7:0] t);
        mdl_t r;
        int   cand;
        r    = m;
        cand = -1;
        for (int k = 1; k < m.n; k++) begin
            if (cand < 0 && t[3'((m.owner + k) % m.n)]) cand = (m.owner + k) % m.n;
        end
        case (m.ph)
            0: begin
                r.age = m.age + 1;
                if (cand >= 0 && r.age >= m.mn && (!t[3'(m.owner)] || r.age >= m.mx)) begin
                    r.ph   = 1;
                    r.nxt  = cand;
                    r.left = m.yc;
                    r.age  = 0;
                end else if (r.age > m.mx) begin
                    r.age = m.mx;
                end
            end
            1: begin
                r.left = m.left - 1;
                if (r.left == 0) begin
                    if (m.ac == 0) begin
                        r.ph    = 0;
                        r.owner = m.nxt;
                        r.age   = 0;
                    end else begin
                        r.ph   = 2;
                        r.left = m.ac;
                    end
                end
            end
            default: begin
                r.left = m.left - 1;
                if (r.left == 0) begin
                    r.ph    = 0;
                    r.owner = m.nxt;
                    r.age   = 0;
                end
            end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] exp_l(input mdl_t m);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < m.n; i++) begin
            if (i == m.owner && m.ph == 0)      v[3*i +: 3] = 3'b001;
            else if (i == m.owner && m.ph == 1) v[3*i +: 3] = 3'b010;
            else                                v[3*i +: 3] = 3'b100;
        end
        return v;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, "_L2"},  32'(L2),  exp_l(m2));
        check({tag, "_G2"},  32'(G2),  32'(m2.owner));
        check({tag, "_PH2"}, 32'(PH2), 32'(m2.ph));
        check({tag, "_L4"},  32'(L4),  exp_l(m4));
        check({tag, "_G4"},  32'(G4),  32'(m4.owner));
        check({tag, "_PH4"}, 32'(PH4), 32'(m4.ph));
    endtask

    // Called at a falling edge; ends at the next falling edge with outputs checked.
    task automatic tick(input logic [1:0] t2, input logic [3:0] t4, input string tag);
        T2 = t2;
        T4 = t4;
        @(posedge CLK);
        m2 = step(m2, {6'b0, t2});
        m4 = step(m4, {4'b0, t4});
        @(negedge CLK);
        compare_all(tag);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        R  = 1'b1;
        T2 = '0;
        T4 = '0;
        #1;
        m2 = mreset(m2);
        m4 = mreset(m4);
        compare_all("rst");
        @(negedge CLK);
        R = 1'b0;
    endtask

    initial begin
        int run;
        int last_chg;
        logic [0:0] prev_g;
        logic [1:0] rt2;
        logic [3:0] rt4;

        n_chk = 0;
        n_err = 0;
        R     = 1'b1;
        T2    = '0;
        T4    = '0;
        m2 = '{n:2, mn:4, mx:8, yc:2, ac:1, owner:0, ph:0, age:0, left:0, nxt:0};
        m4 = '{n:4, mn:4, mx:8, yc:2, ac:1, owner:0, ph:0, age:0, left:0, nxt:0};

        // Idle: no demand keeps approach 0 green indefinitely.
        do_reset();
        for (int i = 0; i < 20; i++) tick(2'b00, 4'b0000, "idle");
        check("idle_L2_const", 32'(L2), 32'h21);
        check("idle_G2_const", 32'(G2), 32'd0);

        // Single handover; 4-way skips idle approaches to reach 3.
        do_reset();
        for (int i = 0; i < 4; i++) tick(2'b10, 4'b1000, "ho");
        check("ho_yellow_PH2", 32'(PH2), 32'd1);
        for (int i = 0; i < 3; i++) tick(2'b10, 4'b1000, "ho");
        check("ho_L2_hi_green", 32'(L2[5:3]), 32'h1);
        check("ho_G2_is1", 32'(G2), 32'd1);
        check("skip_G4_is3", 32'(G4), 32'd3);
        for (int i = 0; i < 7; i++) tick(2'b10, 4'b0001, "wrap");
        check("wrap_G4_is0", 32'(G4), 32'd0);
        check("wrap_PH4_green", 32'(PH4), 32'd0);

        // Async reset in the middle of yellow.
        do_reset();
        for (int i = 0; i < 5; i++) tick(2'b10, 4'b0000, "pre_ar");
        R = 1'b1;
        #1;
        check("async_L2", 32'(L2), 32'h21);
        check("async_PH2", 32'(PH2), 32'd0);
        m2 = mreset(m2);
        m4 = mreset(m4);
        @(negedge CLK);
        R = 1'b0;
        for (int i = 0; i < 7; i++) tick(2'b10, 4'b0000, "resume");
        check("resume_G2", 32'(G2), 32'd1);

        // Short pulse inside the minimum-green window must not cause a handover.
        do_reset();
        tick(2'b00, 4'b0000, "pulse");
        tick(2'b10, 4'b0100, "pulse");
        for (int i = 0; i < 15; i++) tick(2'b00, 4'b0000, "pulse");
        check("pulse_G2", 32'(G2), 32'd0);
        check("pulse_PH2", 32'(PH2), 32'd0);

        // Full contention: 8-cycle greens, 11-cycle handover period.
        do_reset();
        run      = 1;
        last_chg = 0;
        prev_g   = G2;
        for (int c = 1; c <= 44; c++) begin
            tick(2'b11, 4'b1111, "cont");
            if (PH2 == 2'd0) begin
                run++;
            end else if (run > 0) begin
                check("green_len", 32'(run), 32'd8);
                run = 0;
            end
            if (G2 != prev_g) begin
                check("handover_period", 32'(c - last_chg), 32'd11);
                last_chg = c;
                prev_g   = G2;
            end
        end

        // Random sensor activity, sometimes held for several cycles.
        do_reset();
        rt2 = '0;
        rt4 = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3, 0) == 0) rt2 = 2'($urandom);
            if ($urandom_range(3, 0) == 0) rt4 = 4'($urandom);
            tick(rt2, rt4, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
